// File: rtl/ddr_arbiter.sv
// Fixed-priority, burst-granular arbiter sharing one DDRAM port between
// requesters; index 0 wins, and an accepted burst always runs to completion.
module ddr_arbiter #(
    parameter int PORTS       = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_WIDTH = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [PORTS-1:0]                in_rd,
    input  logic [PORTS-1:0]                in_wr,
    input  logic [PORTS*ADDR_WIDTH-1:0]     in_addr,
    input  logic [PORTS*DATA_WIDTH/8-1:0]   in_mask,
    input  logic [PORTS*DATA_WIDTH-1:0]     in_din,
    input  logic [PORTS*BURST_WIDTH-1:0]    in_burstLength,
    output logic [PORTS-1:0]                in_waitReq,
    output logic [PORTS-1:0]                in_valid,
    output logic [DATA_WIDTH-1:0]           in_dout,
    output logic                            ddr_rd,
    output logic                            ddr_wr,
    output logic [ADDR_WIDTH-1:0]           ddr_addr,
    output logic [DATA_WIDTH/8-1:0]         ddr_mask,
    output logic [DATA_WIDTH-1:0]           ddr_din,
    output logic [BURST_WIDTH-1:0]          ddr_burstLength,
    input  logic                            ddr_waitReq,
    input  logic                            ddr_valid,
    input  logic [DATA_WIDTH-1:0]           ddr_dout
);
    localparam int MW = DATA_WIDTH / 8;
    localparam int OW = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ_WAIT,
        S_WRITE_BURST
    } state_t;

    state_t                 r_state, w_state_nx;
    logic [OW-1:0]          r_owner, w_owner_nx;
    logic [BURST_WIDTH-1:0] r_cnt, w_cnt_nx;
    logic [BURST_WIDTH-1:0] r_len, w_len_nx;

    logic [ADDR_WIDTH-1:0]  w_addr [PORTS];
    logic [MW-1:0]          w_mask [PORTS];
    logic [DATA_WIDTH-1:0]  w_din  [PORTS];
    logic [BURST_WIDTH-1:0] w_bl   [PORTS];

    logic                   w_any;
    logic [OW-1:0]          w_win;
    logic [OW-1:0]          w_sel;
    logic [BURST_WIDTH-1:0] w_blen_raw;
    logic [BURST_WIDTH-1:0] w_blen;
    logic [BURST_WIDTH-1:0] w_cnt_inc;

    for (genvar g = 0; g < PORTS; g++) begin : g_slice
        assign w_addr[g] = in_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_mask[g] = in_mask[g*MW +: MW];
        assign w_din[g]  = in_din[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_bl[g]   = in_burstLength[g*BURST_WIDTH +: BURST_WIDTH];
    end

    // Scan downward so the lowest requesting index is the last one written.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (in_rd[i] | in_wr[i]) begin
                w_any = 1'b1;
                w_win = OW'(i);
            end
        end
    end

    assign w_sel      = (r_state == S_IDLE) ? w_win : r_owner;
    assign w_blen_raw = w_bl[w_sel];
    assign w_blen     = (w_blen_raw == '0) ? BURST_WIDTH'(1) : w_blen_raw;
    assign w_cnt_inc  = r_cnt + BURST_WIDTH'(1);
    assign in_dout    = ddr_dout;

    always_comb begin
        ddr_rd          = 1'b0;
        ddr_wr          = 1'b0;
        ddr_addr        = w_addr[w_sel];
        ddr_mask        = w_mask[w_sel];
        ddr_din         = w_din[w_sel];
        ddr_burstLength = w_blen;
        in_waitReq      = '1;
        in_valid        = '0;
        w_state_nx      = r_state;
        w_owner_nx      = r_owner;
        w_cnt_nx        = r_cnt;
        w_len_nx        = r_len;
        // Reset gates the bus immediately, even mid-burst.
        if (!reset) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        ddr_rd            = in_rd[w_win];
                        ddr_wr            = in_wr[w_win] & ~in_rd[w_win];
                        in_waitReq[w_win] = ddr_waitReq;
                        if (!ddr_waitReq) begin
                            w_owner_nx = w_win;
                            w_len_nx   = w_blen;
                            if (in_rd[w_win]) begin
                                w_state_nx = S_READ_WAIT;
                                w_cnt_nx   = '0;
                            end else if (w_blen != BURST_WIDTH'(1)) begin
                                w_state_nx = S_WRITE_BURST;
                                w_cnt_nx   = BURST_WIDTH'(1);
                            end
                        end
                    end
                end
                S_READ_WAIT: begin
                    in_valid[r_owner] = ddr_valid;
                    if (ddr_valid) begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc == r_len) w_state_nx = S_IDLE;
                    end
                end
                S_WRITE_BURST: begin
                    ddr_wr              = in_wr[r_owner];
                    in_waitReq[r_owner] = ddr_waitReq;
                    if (in_wr[r_owner] && !ddr_waitReq) begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc == r_len) w_state_nx = S_IDLE;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_cnt   <= w_cnt_nx;
            r_len   <= w_len_nx;
        end
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed-vector bench for ddr_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, well before the next rising edge.
module tb_ddr_arbiter;
    localparam int P  = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int MW = DW / 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [P-1:0]      in_rd, in_wr;
    logic [P*AW-1:0]   in_addr;
    logic [P*MW-1:0]   in_mask;
    logic [P*DW-1:0]   in_din;
    logic [P*BW-1:0]   in_burstLength;
    logic [P-1:0]      in_waitReq, in_valid;
    logic [DW-1:0]     in_dout;
    logic              ddr_rd, ddr_wr;
    logic [AW-1:0]     ddr_addr;
    logic [MW-1:0]     ddr_mask;
    logic [DW-1:0]     ddr_din;
    logic [BW-1:0]     ddr_burstLength;
    logic              ddr_waitReq, ddr_valid;
    logic [DW-1:0]     ddr_dout;

    int n_chk = 0;
    int n_err = 0;
    int nv;

    ddr_arbiter #(.PORTS(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .BURST_WIDTH(BW)) dut (
        .clock(clock), .reset(reset),
        .in_rd(in_rd), .in_wr(in_wr), .in_addr(in_addr),
        .in_mask(in_mask), .in_din(in_din),
        .in_burstLength(in_burstLength),
        .in_waitReq(in_waitReq), .in_valid(in_valid), .in_dout(in_dout),
        .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr),
        .ddr_mask(ddr_mask), .ddr_din(ddr_din),
        .ddr_burstLength(ddr_burstLength),
        .ddr_waitReq(ddr_waitReq), .ddr_valid(ddr_valid),
        .ddr_dout(ddr_dout)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: sequence did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int p, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [BW-1:0] bl,
                       input logic [DW-1:0] d);
        logic [MW-1:0] m;
        m = 8'h11 << p;
        in_rd[p]                 = rd;
        in_wr[p]                 = wr;
        in_addr[p*AW +: AW]      = a;
        in_burstLength[p*BW +: BW] = bl;
        in_din[p*DW +: DW]       = d;
        in_mask[p*MW +: MW]      = m;
    endtask

    task automatic clr();
        in_rd = '0;
        in_wr = '0;
    endtask

    initial begin
        reset = 1'b1;
        in_rd = '0; in_wr = '0; in_addr = '0; in_mask = '0;
        in_din = '0; in_burstLength = '0;
        ddr_waitReq = 1'b0; ddr_valid = 1'b0; ddr_dout = '0;

        // reset: requests and stray valids are masked
        @(negedge clock);
        @(negedge clock);
        req(0, 1'b1, 1'b0, 32'h10, 8'd1, 64'h0);
        ddr_valid = 1'b1;
        #1;
        chk("rst_waitReq", in_waitReq, 3'b111);
        chk("rst_ddr_rd", ddr_rd, 1'b0);
        chk("rst_ddr_wr", ddr_wr, 1'b0);
        chk("rst_in_valid", in_valid, 3'b000);
        @(negedge clock);
        reset = 1'b0; clr(); ddr_valid = 1'b0;
        #1;
        chk("idle_ddr_rd", ddr_rd, 1'b0);
        chk("idle_ddr_wr", ddr_wr, 1'b0);
        chk("idle_waitReq", in_waitReq, 3'b111);

        // port 2 read burst 4, two stall cycles
        @(negedge clock);
        req(2, 1'b1, 1'b0, 32'h3000_0000, 8'd4, 64'h0);
        ddr_waitReq = 1'b1;
        #1;
        chk("t1_rd_c0", ddr_rd, 1'b1);
        chk("t1_addr", ddr_addr, 32'h3000_0000);
        chk("t1_bl", ddr_burstLength, 8'd4);
        chk("t1_wait_c0", in_waitReq, 3'b111);
        @(negedge clock);
        #1;
        chk("t1_rd_c1", ddr_rd, 1'b1);
        @(negedge clock);
        ddr_waitReq = 1'b0;
        #1;
        chk("t1_rd_c2", ddr_rd, 1'b1);
        chk("t1_wait_c2", in_waitReq, 3'b011);
        for (int b = 0; b < 4; b++) begin
            @(negedge clock);
            clr(); ddr_valid = 1'b0;
            #1;
            chk("t1_gap_valid", in_valid, 3'b000);
            chk("t1_gap_rd", ddr_rd, 1'b0);
            chk("t1_gap_wait", in_waitReq, 3'b111);
            @(negedge clock);
            ddr_valid = 1'b1;
            ddr_dout  = 64'hA5A5_0000_0000_0000 | 64'(b);
            if (b == 3) begin
                req(1, 1'b1, 1'b0, 32'h1000_0040, 8'd1, 64'h0);
                ddr_waitReq = 1'b1;
            end
            #1;
            chk("t1_beat_valid", in_valid, 3'b100);
            chk("t1_beat_dout", in_dout,
                64'hA5A5_0000_0000_0000 | 64'(b));
            if (b == 3) chk("t1_last_rd", ddr_rd, 1'b0);
        end
        @(negedge clock);
        ddr_valid = 1'b0;
        #1;
        chk("t1_idle_rd", ddr_rd, 1'b1);
        chk("t1_idle_addr", ddr_addr, 32'h1000_0040);
        @(negedge clock);
        clr(); ddr_waitReq = 1'b0;
        #1;
        chk("t1_clr_rd", ddr_rd, 1'b0);

        // ports 0 and 1 write burst 1 together
        @(negedge clock);
        req(0, 1'b0, 1'b1, 32'h100, 8'd1, 64'h1111);
        req(1, 1'b0, 1'b1, 32'h200, 8'd1, 64'h2222);
        #1;
        chk("t2_p0_wr", ddr_wr, 1'b1);
        chk("t2_p0_addr", ddr_addr, 32'h100);
        chk("t2_p0_din", ddr_din, 64'h1111);
        chk("t2_p0_mask", ddr_mask, 8'h11);
        chk("t2_p0_wait", in_waitReq, 3'b110);
        @(negedge clock);
        in_wr[0] = 1'b0;
        #1;
        chk("t2_p1_wr", ddr_wr, 1'b1);
        chk("t2_p1_addr", ddr_addr, 32'h200);
        chk("t2_p1_din", ddr_din, 64'h2222);
        chk("t2_p1_mask", ddr_mask, 8'h22);
        chk("t2_p1_wait", in_waitReq, 3'b101);
        @(negedge clock);
        clr();
        #1;
        chk("t2_clr_wr", ddr_wr, 1'b0);

        // rd and wr together on one port: rd wins
        @(negedge clock);
        req(2, 1'b1, 1'b1, 32'h3000_0080, 8'd1, 64'h0);
        ddr_waitReq = 1'b1;
        #1;
        chk("rw_rd", ddr_rd, 1'b1);
        chk("rw_wr", ddr_wr, 1'b0);
        @(negedge clock);
        clr(); ddr_waitReq = 1'b0;
        #1;
        chk("rw_clr_rd", ddr_rd, 1'b0);

        // port 1 write burst 8, port 0 arrives after beat 2
        @(negedge clock);
        req(1, 1'b0, 1'b1, 32'h2000_0000, 8'd8, 64'hB0);
        #1;
        chk("t3_b0_wr", ddr_wr, 1'b1);
        chk("t3_b0_bl", ddr_burstLength, 8'd8);
        chk("t3_b0_wait", in_waitReq, 3'b101);
        @(negedge clock);
        req(1, 1'b0, 1'b1, 32'h2000_0000, 8'd8, 64'hB1);
        #1;
        chk("t3_b1_din", ddr_din, 64'hB1);
        for (int b = 2; b < 8; b++) begin
            if (b == 4) begin
                @(negedge clock);
                in_wr[1] = 1'b0; ddr_valid = 1'b1;
                #1;
                chk("t3_pause_wr", ddr_wr, 1'b0);
                chk("t3_pause_valid", in_valid, 3'b000);
                chk("t3_pause_wait", in_waitReq, 3'b101);
                ddr_valid = 1'b0;
            end
            @(negedge clock);
            req(1, 1'b0, 1'b1, 32'h2000_0000, 8'd8, 64'hB0 + 64'(b));
            if (b == 2) req(0, 1'b0, 1'b1, 32'h400, 8'd1, 64'hC0);
            #1;
            chk("t3_beat_wr", ddr_wr, 1'b1);
            chk("t3_beat_addr", ddr_addr, 32'h2000_0000);
            chk("t3_beat_din", ddr_din, 64'hB0 + 64'(b));
            chk("t3_beat_wait", in_waitReq, 3'b101);
        end
        @(negedge clock);
        in_wr[1] = 1'b0;
        #1;
        chk("t3_p0_wr", ddr_wr, 1'b1);
        chk("t3_p0_addr", ddr_addr, 32'h400);
        chk("t3_p0_din", ddr_din, 64'hC0);
        chk("t3_p0_wait", in_waitReq, 3'b110);
        @(negedge clock);
        clr();
        #1;
        chk("t3_clr_wr", ddr_wr, 1'b0);

        // port 2 stalled, port 0 takes over
        @(negedge clock);
        req(2, 1'b1, 1'b0, 32'h3000_0040, 8'd2, 64'h0);
        ddr_waitReq = 1'b1;
        #1;
        chk("t4_p2_addr", ddr_addr, 32'h3000_0040);
        @(negedge clock);
        req(0, 1'b1, 1'b0, 32'h500, 8'd1, 64'h0);
        #1;
        chk("t4_p0_addr", ddr_addr, 32'h500);
        chk("t4_p0_bl", ddr_burstLength, 8'd1);
        chk("t4_stall_wait", in_waitReq, 3'b111);
        @(negedge clock);
        ddr_waitReq = 1'b0;
        #1;
        chk("t4_p0_rd", ddr_rd, 1'b1);
        chk("t4_p0_wait", in_waitReq, 3'b110);
        @(negedge clock);
        in_rd[0] = 1'b0; ddr_valid = 1'b1; ddr_dout = 64'hD40;
        #1;
        chk("t4_p0_valid", in_valid, 3'b001);
        chk("t4_p0_dout", in_dout, 64'hD40);
        chk("t4_rw_rd", ddr_rd, 1'b0);
        @(negedge clock);
        ddr_valid = 1'b0;
        #1;
        chk("t4_p2_rd", ddr_rd, 1'b1);
        chk("t4_p2_addr2", ddr_addr, 32'h3000_0040);
        chk("t4_p2_wait", in_waitReq, 3'b011);
        @(negedge clock);
        in_rd[2] = 1'b0; ddr_valid = 1'b1; ddr_dout = 64'hD41;
        #1;
        chk("t4_p2_v0", in_valid, 3'b100);
        @(negedge clock);
        ddr_dout = 64'hD42;
        #1;
        chk("t4_p2_v1", in_valid, 3'b100);
        chk("t4_p2_dout", in_dout, 64'hD42);
        @(negedge clock);
        ddr_valid = 1'b0;
        #1;
        chk("t4_end_valid", in_valid, 3'b000);

        // port 1 read burst 16, reset after beat 5
        @(negedge clock);
        req(1, 1'b1, 1'b0, 32'h600, 8'd16, 64'h0);
        #1;
        chk("t5_rd", ddr_rd, 1'b1);
        chk("t5_wait", in_waitReq, 3'b101);
        for (int b = 0; b < 5; b++) begin
            @(negedge clock);
            in_rd[1] = 1'b0; ddr_valid = 1'b1;
            ddr_dout = 64'hE0 + 64'(b);
            #1;
            chk("t5_beat_valid", in_valid, 3'b010);
        end
        @(negedge clock);
        reset = 1'b1;
        req(2, 1'b1, 1'b0, 32'h700, 8'd1, 64'h0);
        #1;
        chk("t5_rst_rd", ddr_rd, 1'b0);
        chk("t5_rst_wait", in_waitReq, 3'b111);
        chk("t5_rst_valid", in_valid, 3'b000);
        @(negedge clock);
        reset = 1'b0; in_rd[2] = 1'b0;
        #1;
        chk("t5_stray_valid", in_valid, 3'b000);
        chk("t5_stray_rd", ddr_rd, 1'b0);
        @(negedge clock);
        ddr_valid = 1'b0; in_rd[2] = 1'b1;
        #1;
        chk("t5_new_rd", ddr_rd, 1'b1);
        chk("t5_new_addr", ddr_addr, 32'h700);
        chk("t5_new_wait", in_waitReq, 3'b011);
        @(negedge clock);
        in_rd[2] = 1'b0; ddr_valid = 1'b1; ddr_dout = 64'hF0;
        #1;
        chk("t5_new_valid", in_valid, 3'b100);
        chk("t5_new_dout", in_dout, 64'hF0);
        @(negedge clock);
        ddr_valid = 1'b0;
        #1;
        chk("t5_end_valid", in_valid, 3'b000);

        // burst length 0 write, then burst length 255 read
        @(negedge clock);
        req(0, 1'b0, 1'b1, 32'h800, 8'd0, 64'h99);
        #1;
        chk("t6_wr", ddr_wr, 1'b1);
        chk("t6_bl0_as1", ddr_burstLength, 8'd1);
        @(negedge clock);
        clr();
        req(1, 1'b1, 1'b0, 32'h900, 8'd255, 64'h0);
        #1;
        chk("t6_rd_after_len0", ddr_rd, 1'b1);
        chk("t6_rd_wr", ddr_wr, 1'b0);
        chk("t6_rd_addr", ddr_addr, 32'h900);
        chk("t6_rd_bl", ddr_burstLength, 8'd255);
        nv = 0;
        for (int b = 0; b < 255; b++) begin
            @(negedge clock);
            in_rd[1] = 1'b0; ddr_valid = 1'b1; ddr_dout = 64'(b);
            #1;
            if (in_valid == 3'b010) nv++;
        end
        chk("t6_beats_255", 64'(nv), 64'd255);
        @(negedge clock);
        req(0, 1'b1, 1'b0, 32'hA00, 8'd1, 64'h0);
        ddr_waitReq = 1'b1;
        #1;
        chk("t6_post_valid", in_valid, 3'b000);
        chk("t6_post_rd", ddr_rd, 1'b1);
        chk("t6_post_addr", ddr_addr, 32'hA00);
        @(negedge clock);
        clr(); ddr_waitReq = 1'b0; ddr_valid = 1'b0;
        #1;
        chk("t6_end_rd", ddr_rd, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ddr_arbiter.md
Name: ddr_arbiter

Overview:
- Shares the single DDRAM port (64-bit, burst-capable, wait-request/valid handshake) between three requesters.
- Port 0: ROM/ioctl download writer. Port 1: sprite framebuffer. Port 2: system framebuffer.
- Sits between the requesters and the top-level ddr_* pins.
- Fixed-priority grant at burst granularity. A burst is never interrupted once its first beat is accepted.

Parameters:
- PORTS, 3, number of requesters; index 0 has the highest priority.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 64, data bus width.
- BURST_WIDTH, 8, burst length field width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_rd  in  PORTS  per-port read request
- in_wr  in  PORTS  per-port write request
- in_addr  in  PORTS*ADDR_WIDTH  per-port address; port i occupies slice i
- in_mask  in  PORTS*DATA_WIDTH/8  per-port byte enables
- in_din  in  PORTS*DATA_WIDTH  per-port write data
- in_burstLength  in  PORTS*BURST_WIDTH  per-port burst length
- in_waitReq  out  PORTS  per-port stall
- in_valid  out  PORTS  per-port read data valid
- in_dout  out  DATA_WIDTH  read data, broadcast to all ports; qualify with in_valid
- ddr_rd  out  1  read request to DDR
- ddr_wr  out  1  write request to DDR
- ddr_addr  out  ADDR_WIDTH  DDR address
- ddr_mask  out  DATA_WIDTH/8  DDR byte enables
- ddr_din  out  DATA_WIDTH  DDR write data
- ddr_burstLength  out  BURST_WIDTH  DDR burst length
- ddr_waitReq  in  1  DDR stall
- ddr_valid  in  1  DDR read data valid
- ddr_dout  in  DATA_WIDTH  DDR read data

Behaviour:
- State machine: IDLE, READ_WAIT, WRITE_BURST. Registers: owner (2b), beat counter (BURST_WIDTH), latched burst length.
- A burstLength of 0 is treated as 1 everywhere.
- Reset: state=IDLE, counter=0, owner=0.
  - Outputs during and after reset until a request arrives: ddr_rd=0, ddr_wr=0, in_valid=0, in_waitReq=all 1s while reset is high.
- IDLE, winner selection:
  - The winner is the lowest index i with in_rd[i]|in_wr[i].
  - The winner's rd/wr/addr/mask/din/burstLength are forwarded combinationally to ddr_* (zero added latency).
  - in_waitReq[winner]=ddr_waitReq; every other port sees in_waitReq=1.
  - With no requester: ddr_rd=ddr_wr=0 and the other ddr_* outputs are don't-care.
- IDLE, acceptance (ddr_rd|ddr_wr) & !ddr_waitReq: latch owner and burst length.
  - Read: go to READ_WAIT, counter=0.
  - Write with length 1: stay in IDLE.
  - Write with length >1: go to WRITE_BURST, counter=1.
- IDLE, stall: while ddr_waitReq=1, the grant is not latched. A higher-priority request arriving during the stall takes over the forwarding next cycle.
- Requester rule: a requester must hold its request stable while its waitReq=1.
- IDLE, simultaneous rd and wr on one port: rd wins, wr stays stalled.
- READ_WAIT:
  - ddr_rd=ddr_wr=0. All in_waitReq=1.
  - in_valid[owner]=ddr_valid; other in_valid bits 0. in_dout=ddr_dout.
  - Each ddr_valid increments the counter. The valid that makes the counter equal the latched length returns the FSM to IDLE.
  - New arbitration happens in the cycle after the last beat.
- WRITE_BURST:
  - Only the owner is forwarded: ddr_wr=in_wr[owner]; ddr_rd=0.
  - Each accepted beat (ddr_wr & !ddr_waitReq) increments the counter.
  - The beat that makes counter==length returns the FSM to IDLE.
  - A deasserted in_wr[owner] mid-burst leaves the FSM waiting in WRITE_BURST; there is no timeout.
- ddr_valid while in IDLE or WRITE_BURST is ignored: no in_valid is raised.
- Reset mid-burst: the FSM returns to IDLE and ddr_rd/ddr_wr drop the same cycle. Beats still outstanding at the DDR are dropped.
- Counter arithmetic is BURST_WIDTH-bit. The maximum length 255 must not wrap before completion.

Test Plan:
- Port 2 reads addr 0x30000000, burst 4; DDR gives 2 waitReq cycles, then 4 valid beats 2 cycles apart:
  - ddr_rd is held for 3 cycles;
  - in_valid[2] pulses 4 times with matching data;
  - in_valid[0..1] stay 0;
  - FSM is in IDLE 1 cycle after beat 4.
- Ports 0 and 1 both write burst 1 in the same cycle, waitReq=0:
  - port 0 is accepted first, in_waitReq[1]=1;
  - port 1 is accepted the next cycle.
- Port 1 write burst 8, port 0 requests after beat 2:
  - all 8 port-1 beats complete;
  - in_waitReq[0]=1 throughout;
  - port 0 is granted the cycle after beat 8.
- Port 2 read burst 2 is stalled by waitReq; port 0 read asserts during the stall:
  - ddr_addr switches to port 0's address;
  - port 0 is served first, then port 2.
- Port 1 read burst 16, reset asserted after beat 5:
  - ddr_rd=0 and in_waitReq=all 1s while reset is high;
  - stray ddr_valid after reset produces no in_valid;
  - a fresh port-2 burst 1 then completes normally.
- Burst length 0 write and burst length 255 read:
  - the write completes in 1 beat;
  - the read completes after exactly 255 valid beats.
